// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: store size encodings, store FSM states and the store legality check
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ERR} state_t;

    function automatic logic store_err(input logic [1:0] a, input logic [1:0] sz);
        return sz == 2'b11 || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: little-endian merge of byte/half/word store data into an existing word
module store_lane_merge
    import cpu_mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    output logic [31:0] merged
);

    logic [31:0] mask;
    logic [31:0] src;

    always_comb begin
        mask   = size == SZ_BYTE ? 32'h0000_00FF << {lane, 3'b000}
               : size == SZ_HALF ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF)
               : 32'hFFFF_FFFF;
        src    = size == SZ_BYTE ? {4{data[7:0]}} : size == SZ_HALF ? {2{data[15:0]}} : data;
        merged = (old_word & ~mask) | (src & mask);
    end

endmodule

// File: rtl/store_rmw_unit.sv
// store_rmw_unit: sb/sh/sw store path using read-modify-write on a word-wide memory without byte enables
module store_rmw_unit
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        mem_we,
    output logic [31:0] mem_wdata
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [1:0]    lane;
    logic [1:0]    size;
    logic [31:0]   data;
    logic [31:0]   wbuf;
    logic [31:0]   merged;
    logic [CW-1:0] cnt;

    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .data     (data),
        .lane     (lane),
        .size     (size),
        .merged   (merged)
    );

    assign req_ready = state == S_IDLE;
    assign busy      = state != S_IDLE;
    assign mem_wdata = wbuf;

    // Strobes are registered on the edge that enters their state, so each lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_addr <= '0;
            wbuf     <= '0;
            lane     <= '0;
            size     <= '0;
            data     <= '0;
            cnt      <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    lane <= req_addr[1:0];
                    size <= req_size;
                    data <= req_wdata;
                    wbuf <= req_wdata;
                    if (store_err(req_addr[1:0], req_size)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (req_size == SZ_WORD) begin
                        state    <= S_WR;
                        mem_we   <= 1'b1;
                        done     <= 1'b1;
                        mem_addr <= {req_addr[31:2], 2'b00};
                    end else begin
                        state    <= S_RD;
                        mem_re   <= 1'b1;
                        mem_addr <= {req_addr[31:2], 2'b00};
                    end
                end
                S_RD: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (mem_rvalid) begin
                    wbuf   <= merged;
                    state  <= S_WR;
                    mem_we <= 1'b1;
                    done   <= 1'b1;
                end else if (cnt == LAST) begin
                    state    <= S_ERR;
                    err      <= 1'b1;
                    mem_addr <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// tb_store_rmw_unit: directed scenario checks for the store read-modify-write unit
module tb_store_rmw_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_we;
    logic [31:0] mem_wdata;

    int n = 0;
    int fails = 0;
    int re_cnt = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic [5:0] st;

    assign st = {req_ready, busy, done, err, mem_re, mem_we};

    store_rmw_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_re) re_cnt <= re_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_size  = 2'b00;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n++; if (st !== 6'b100000) begin fails++; $display("FAIL reset_flags: got %b want 100000", st); end
        n++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
    endtask

    task automatic test_sw;
        int re0, we0, d0;
        re0 = re_cnt; we0 = we_cnt; d0 = done_cnt;
        issue(32'h104, 32'hDEAD_BEEF, 2'b10);
        n++; if (st !== 6'b011001) begin fails++; $display("FAIL sw_c1_flags: got %b want 011001", st); end
        n++; if (mem_addr !== 32'h104) begin fails++; $display("FAIL sw_addr: got %h want 00000104", mem_addr); end
        n++; if (mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
        tick();
        n++; if (st !== 6'b100000) begin fails++; $display("FAIL sw_c2_flags: got %b want 100000", st); end
        n++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL sw_idle_addr: got %h want 0", mem_addr); end
        n++; if (re_cnt - re0 != 0 || we_cnt - we0 != 1 || done_cnt - d0 != 1) begin
            fails++; $display("FAIL sw_pulses: re %0d we %0d done %0d want 0 1 1", re_cnt - re0, we_cnt - we0, done_cnt - d0);
        end
    endtask

    task automatic test_sb;
        mem_rdata = 32'hAABB_CCDD;
        issue(32'h102, 32'h0000_0011, 2'b00);
        n++; if (st !== 6'b010010) begin fails++; $display("FAIL sb_c1_flags: got %b want 010010", st); end
        n++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL sb_rd_addr: got %h want 00000100", mem_addr); end
        tick();
        n++; if (st !== 6'b010000) begin fails++; $display("FAIL sb_c2_flags: got %b want 010000", st); end
        tick();
        n++; if (st !== 6'b010000) begin fails++; $display("FAIL sb_c3_flags: got %b want 010000", st); end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        n++; if (st !== 6'b011001) begin fails++; $display("FAIL sb_c4_flags: got %b want 011001", st); end
        n++; if (mem_wdata !== 32'hAA11_CCDD) begin fails++; $display("FAIL sb_wdata: got %h want aa11ccdd", mem_wdata); end
        n++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL sb_wr_addr: got %h want 00000100", mem_addr); end
        tick();
        n++; if (st !== 6'b100000) begin fails++; $display("FAIL sb_c5_flags: got %b want 100000", st); end
    endtask

    task automatic test_merge_lanes;
        logic [31:0] va [6] = '{32'h102, 32'h100, 32'h103, 32'h100, 32'h101, 32'h1FE};
        logic [31:0] vd [6] = '{32'h0000_5566, 32'h0000_5566, 32'hFFFF_FF77, 32'hFFFF_FFEE, 32'h1234_5699, 32'hFFFF_1357};
        logic [1:0]  vs [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        logic [31:0] ve [6] = '{32'h5566_CCDD, 32'hAABB_5566, 32'h77BB_CCDD, 32'hAABB_CCEE, 32'hAABB_99DD, 32'h1357_CCDD};
        logic [31:0] wa;
        mem_rdata = 32'hAABB_CCDD;
        for (int i = 0; i < 6; i++) begin
            wa = va[i];
            wa[1:0] = 2'b00;
            issue(va[i], vd[i], vs[i]);
            n++; if (st !== 6'b010010) begin fails++; $display("FAIL merge%0d_rd: got %b want 010010", i, st); end
            tick();
            mem_rvalid = 1'b1;
            tick();
            mem_rvalid = 1'b0;
            n++; if (st !== 6'b011001) begin fails++; $display("FAIL merge%0d_wr: got %b want 011001", i, st); end
            n++; if (mem_wdata !== ve[i]) begin fails++; $display("FAIL merge%0d_wdata: got %h want %h", i, mem_wdata, ve[i]); end
            n++; if (mem_addr !== wa) begin fails++; $display("FAIL merge%0d_addr: got %h want %h", i, mem_addr, wa); end
            tick();
        end
    endtask

    task automatic test_misalign;
        logic [31:0] va [4] = '{32'h101, 32'h106, 32'h100, 32'h103};
        logic [1:0]  vs [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        int re0, we0;
        for (int i = 0; i < 4; i++) begin
            re0 = re_cnt; we0 = we_cnt;
            issue(va[i], 32'hCAFE_F00D, vs[i]);
            n++; if (st !== 6'b010100) begin fails++; $display("FAIL misalign%0d_c1: got %b want 010100", i, st); end
            n++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL misalign%0d_addr: got %h want 0", i, mem_addr); end
            tick();
            n++; if (st !== 6'b100000) begin fails++; $display("FAIL misalign%0d_c2: got %b want 100000", i, st); end
            n++; if (re_cnt != re0 || we_cnt != we0) begin fails++; $display("FAIL misalign%0d_mem: re %0d we %0d want 0 0", i, re_cnt - re0, we_cnt - we0); end
        end
    endtask

    task automatic test_timeout;
        int we0, cyc;
        we0 = we_cnt;
        cyc = 1;
        mem_rdata = 32'h1111_1111;
        issue(32'h200, 32'h0000_00AB, 2'b00);
        mem_rvalid = 1'b1;
        tick();
        cyc++;
        mem_rvalid = 1'b0;
        n++; if (st !== 6'b010000) begin fails++; $display("FAIL timeout_spurious: got %b want 010000", st); end
        while (!err && cyc < 40) begin
            tick();
            cyc++;
        end
        n++; if (cyc < 17 || cyc > 18) begin fails++; $display("FAIL timeout_cycle: err at cycle %0d want 17..18", cyc); end
        n++; if (st !== 6'b010100) begin fails++; $display("FAIL timeout_flags: got %b want 010100", st); end
        n++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL timeout_addr: got %h want 0", mem_addr); end
        tick();
        n++; if (st !== 6'b100000) begin fails++; $display("FAIL timeout_idle: got %b want 100000", st); end
        n++; if (we_cnt != we0) begin fails++; $display("FAIL timeout_we: got %0d writes want 0", we_cnt - we0); end
    endtask

    task automatic test_reset_mid;
        int we0;
        we0 = we_cnt;
        mem_rdata = 32'h2222_2222;
        issue(32'h300, 32'h0000_0044, 2'b00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n++; if (st !== 6'b100000) begin fails++; $display("FAIL rstmid_flags: got %b want 100000", st); end
        n++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rstmid_bus: addr %h wdata %h want 0 0", mem_addr, mem_wdata); end
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        tick();
        n++; if (we_cnt != we0 || st !== 6'b100000) begin fails++; $display("FAIL rstmid_late: writes %0d flags %b want 0 100000", we_cnt - we0, st); end
        issue(32'h400, 32'h1234_5678, 2'b10);
        n++; if (st !== 6'b011001 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h400) begin
            fails++; $display("FAIL rstmid_sw: flags %b wdata %h addr %h want 011001 12345678 00000400", st, mem_wdata, mem_addr);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        issue(32'h10, 32'hA5A5_0001, 2'b10);
        n++; if (st !== 6'b011001 || mem_wdata !== 32'hA5A5_0001) begin fails++; $display("FAIL b2b_first: flags %b wdata %h want 011001 a5a50001", st, mem_wdata); end
        tick();
        issue(32'h20, 32'h5A5A_0002, 2'b10);
        n++; if (st !== 6'b011001 || mem_wdata !== 32'h5A5A_0002 || mem_addr !== 32'h20) begin
            fails++; $display("FAIL b2b_second: flags %b wdata %h addr %h want 011001 5a5a0002 00000020", st, mem_wdata, mem_addr);
        end
        tick();
        issue(32'h31, 32'h0, 2'b01);
        n++; if (st !== 6'b010100) begin fails++; $display("FAIL b2b_err: got %b want 010100", st); end
        tick();
        issue(32'h30, 32'h5A5A_0003, 2'b10);
        n++; if (st !== 6'b011001 || mem_wdata !== 32'h5A5A_0003) begin fails++; $display("FAIL b2b_after_err: flags %b wdata %h want 011001 5a5a0003", st, mem_wdata); end
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_size   = 2'b00;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        test_reset();
        test_sw();
        test_sb();
        test_merge_lanes();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Store-side counterpart to the load path's sign extension: narrows sb/sh/sw store data into the correct byte lanes of a 32-bit word.
- Data memory is word-wide with no byte enables, so sub-word stores use read-modify-write: read the word, merge the new lanes, write the word back.
- Sits between the MEM stage and data memory. Asserts busy so the pipeline stalls until the store completes or errors.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_rvalid before aborting with an error (must be >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- busy  out  1  unit is processing a request (state != IDLE); pipeline stall.
- done  out  1  one-cycle pulse when the write is issued.
- err  out  1  one-cycle pulse on misalignment, illegal size or timeout.
- mem_addr  out  32  word address {addr[31:2],2'b00}; 0 in IDLE.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  32  read data, valid when mem_rvalid is high.
- mem_rvalid  in  1  read data valid; minimum read latency is 1 cycle.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  32  full word to write.

Behaviour:
- Reset: state=IDLE; busy, done, err, mem_re, mem_we=0; mem_addr, mem_wdata, internal buffers and counter=0.
- Reset mid-operation: return to IDLE at the next edge. No mem_we is issued for the aborted request.
- States: IDLE, RD, WAIT, WR, ERR.
- IDLE: req_ready=1. A request is accepted when req_valid is high at a clock edge; addr, wdata and size are latched.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0) or size 11 -> ERR.
  - Word -> WR.
  - Byte or half -> RD.
- RD: mem_re=1 for exactly one cycle, with the word-aligned mem_addr. Clear the counter. Go to WAIT. A mem_rvalid seen in RD is ignored.
- WAIT: if mem_rvalid, latch merge(mem_rdata) into the write buffer and go to WR. Otherwise increment the counter; when the counter reaches TIMEOUT-1 with no rvalid, go to ERR.
- WR: mem_we=1 and done=1 for one cycle. mem_wdata is the buffer (the merged word, or req_wdata for word stores). Return to IDLE.
- ERR: err=1 for one cycle, no memory access. Return to IDLE.
- Merge is little-endian by lane:
  - Byte: lane=addr[1:0]; bits [8*lane+7:8*lane] are replaced by wdata[7:0].
  - Half: addr[1]=0 replaces [15:0]; addr[1]=1 replaces [31:16]; source is wdata[15:0].
  - All other bits keep mem_rdata.
- Latency, counted from the acceptance edge = cycle 0:
  - Word store: mem_we at cycle 1.
  - Sub-word store: mem_re at cycle 1; mem_we one cycle after the rvalid cycle (earliest cycle 3).
  - Error: err at cycle 1, except timeout.
- Back-to-back requests: a new request can be accepted in the cycle after WR or ERR (IDLE). req_valid is not sampled outside IDLE.
- mem_addr holds the word address through RD, WAIT and WR, and is 0 in IDLE and ERR.

Decomposition:
- Shared package, cpu_mem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - State enum for IDLE, RD, WAIT, WR, ERR.
  - The alignment-check function.
- One combinational sub-module, store_lane_merge (old word, data, addr[1:0], size -> merged word). It is unit-testable on its own and reusable by a future write-back cache.

Test Plan:
- sw addr 0x104, data 0xDEADBEEF -> mem_we at cycle 1 with mem_addr 0x104 and mem_wdata 0xDEADBEEF; mem_re never asserted; done pulses once.
- sb addr 0x102, data 0x00000011, memory word 0xAABBCCDD with rvalid 2 cycles after mem_re -> mem_re with addr 0x100, then mem_we with 0xAA11CCDD; busy high from cycle 1 until the WR cycle.
- sh addr 0x102, data 0x5566 over 0xAABBCCDD -> 0x5566CCDD. sh addr 0x100 over the same word -> 0xAABB5566.
- sh addr 0x101 and sw addr 0x106 -> err pulse at cycle 1, no mem_re or mem_we, req_ready high at cycle 2.
- sb with mem_rvalid held low, TIMEOUT=16 -> err pulses and the unit returns to IDLE with no mem_we. A spurious rvalid in the RD cycle is ignored.
- rst asserted during WAIT -> next cycle all outputs 0 and req_ready=1. A late rvalid produces no write. A following sw completes normally.
